// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver with frame-coherent
// input capture, leading-zero blanking, PWM brightness and a dead clock per digit change.
module seg7_scan_driver #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned DIV      = 1000,
    parameter int unsigned BRIGHT_W = 2
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [4*DIGITS-1:0]   DIN,
    input  logic [DIGITS-1:0]     EN,
    input  logic [DIGITS-1:0]     DOT,
    input  logic                  LZB,
    input  logic [BRIGHT_W-1:0]   BRIGHT,
    output logic [7:0]            nHEX,
    output logic [DIGITS-1:0]     nDIG,
    output logic                  FRAME
);

    localparam int unsigned PRE_W = $clog2(DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]    r_pre;
    logic [BRIGHT_W-1:0] r_ph;
    logic [IDX_W-1:0]    r_idx;
    logic [4*DIGITS-1:0] r_din;
    logic [DIGITS-1:0]   r_en;
    logic [DIGITS-1:0]   r_dot;
    logic                r_lzb;
    logic                r_run;

    logic                w_pre_wrap;
    logic                w_ph_wrap;
    logic                w_frame_end;
    logic                w_dead;
    logic                w_carry;
    logic [DIGITS-1:0]   w_sup;
    logic [3:0]          w_nib;
    logic                w_sel_en;
    logic                w_sel_dot;
    logic                w_sel_sup;
    logic                w_on;
    logic [7:0]          w_hex;
    logic [DIGITS-1:0]   w_dig;

    function automatic logic [7:0] font(input logic [3:0] n);
        logic [7:0] f;
        case (n)
            4'h0: f = 8'hC0;
            4'h1: f = 8'hF9;
            4'h2: f = 8'hA4;
            4'h3: f = 8'hB0;
            4'h4: f = 8'h99;
            4'h5: f = 8'h92;
            4'h6: f = 8'h82;
            4'h7: f = 8'hF8;
            4'h8: f = 8'h80;
            4'h9: f = 8'h90;
            4'hA: f = 8'h88;
            4'hB: f = 8'h83;
            4'hC: f = 8'hC6;
            4'hD: f = 8'hA1;
            4'hE: f = 8'h86;
            default: f = 8'h8E;
        endcase
        return f;
    endfunction

    // Counter chain wrap conditions
    always_comb begin
        w_pre_wrap  = (r_pre == PRE_MAX);
        w_ph_wrap   = w_pre_wrap && (r_ph == '1);
        w_frame_end = w_ph_wrap && (r_idx == IDX_MAX);
        w_dead      = (r_pre == '0) && (r_ph == '0);
    end

    // Leading-zero chain from the top digit down; a disabled digit counts as zero
    always_comb begin
        w_sup   = '0;
        w_carry = r_lzb;
        for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
            w_carry  = w_carry && (!r_en[i] || ((r_din[4*i +: 4] == 4'h0) && !r_dot[i]));
            w_sup[i] = w_carry;
        end
    end

    always_comb begin
        w_nib     = 4'h0;
        w_sel_en  = 1'b0;
        w_sel_dot = 1'b0;
        w_sel_sup = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_idx == IDX_W'(i)) begin
                w_nib     = r_din[4*i +: 4];
                w_sel_en  = r_en[i];
                w_sel_dot = r_dot[i];
                w_sel_sup = w_sup[i];
            end
        end
        w_on  = !w_dead && (r_ph <= BRIGHT) && w_sel_en && !w_sel_sup;
        w_hex = w_on ? (font(w_nib) & {~w_sel_dot, 7'h7F}) : 8'hFF;
        w_dig = '1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_dig[i] = !(w_on && (r_idx == IDX_W'(i)));
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_pre <= '0;
            r_ph  <= '0;
            r_idx <= '0;
            r_din <= '0;
            r_en  <= '0;
            r_dot <= '0;
            r_lzb <= 1'b0;
            r_run <= 1'b0;
            nHEX  <= 8'hFF;
            nDIG  <= '1;
            FRAME <= 1'b0;
        end else begin
            r_pre <= w_pre_wrap ? '0 : r_pre + PRE_W'(1);
            if (w_pre_wrap) begin
                r_ph <= r_ph + BRIGHT_W'(1);
            end
            if (w_ph_wrap) begin
                r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
            end
            // Snapshot taken on the last clock of a frame drives the whole next frame
            if (w_frame_end) begin
                r_din <= DIN;
                r_en  <= EN;
                r_dot <= DOT;
                r_lzb <= LZB;
                r_run <= 1'b1;
            end
            nHEX  <= w_hex;
            nDIG  <= w_dig;
            FRAME <= r_run && w_dead && (r_idx == '0);
        end
    end

endmodule
